// File: rtl/bus_arbiter_if.sv
// Bundle of the EU, prefetch and memory-side signals of the bus arbiter.
// The master modport is the arbiter's view; slave is the view of the surrounding requesters/memory.
interface bus_arbiter_if;
   logic [1:0]  eu_command;
   logic [19:0] eu_address;
   logic [15:0] eu_data_out;
   logic [15:0] eu_data_in;
   logic        eu_done;
   logic        pf_request;
   logic [19:0] pf_address;
   logic        pf_flush;
   logic [15:0] pf_data_in;
   logic        pf_done;
   logic [1:0]  mem_command;
   logic [19:0] mem_address;
   logic [15:0] mem_data_out;
   logic [15:0] mem_data_in;
   logic        mem_ready;
   logic [1:0]  bus_owner;
   logic        bus_error;

   modport master (
      input  eu_command, eu_address, eu_data_out, pf_request, pf_address, pf_flush,
             mem_data_in, mem_ready,
      output eu_data_in, eu_done, pf_data_in, pf_done, mem_command, mem_address,
             mem_data_out, bus_owner, bus_error
   );

   modport slave (
      output eu_command, eu_address, eu_data_out, pf_request, pf_address, pf_flush,
             mem_data_in, mem_ready,
      input  eu_data_in, eu_done, pf_data_in, pf_done, mem_command, mem_address,
             mem_data_out, bus_owner, bus_error
   );
endinterface

// File: rtl/bus_arbiter.sv
// Two-requester (EU over prefetch) memory bus arbiter with an IDLE/BUSY/DONE handshake.
// Optional BUSY watchdog enabled by defining BUS_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic          clk,
   input  logic          reset,
   bus_arbiter_if.master bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      r_state;
   logic [1:0]  r_memCommand;
   logic [19:0] r_memAddress;
   logic [15:0] r_memDataOut;
   logic [15:0] r_euDataIn;
   logic [15:0] r_pfDataIn;
   logic        r_euDone;
   logic        r_pfDone;
   logic [1:0]  r_busOwner;
   logic        r_pfFlushed;

   logic        w_euReq;
   logic        w_pfReq;
   logic        w_pfKeep;
   logic        w_timeout;
   logic [15:0] w_rdData;

   assign w_euReq  = (bus.eu_command == 2'd1) || (bus.eu_command == 2'd2);
   assign w_pfReq  = bus.pf_request && !bus.pf_flush;
   // A flush seen on any BUSY edge, including the completing one, drops the prefetch result.
   assign w_pfKeep = !r_pfFlushed && !bus.pf_flush;
   assign w_rdData = bus.mem_ready ? bus.mem_data_in : 16'hFFFF;

`ifdef BUS_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CntW-1:0] r_busyCnt;
   logic            r_busError;

   // mem_ready on the final allowed cycle wins over the timeout.
   assign w_timeout = (r_state == BUSY) && (r_busyCnt == CntW'(TIMEOUT_CYCLES - 1)) &&
                      !bus.mem_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_busyCnt  <= '0;
         r_busError <= 1'b0;
      end else begin
         r_busyCnt  <= (r_state == BUSY) ? r_busyCnt + 1'b1 : '0;
         r_busError <= w_timeout;
      end
   end

   assign bus.bus_error = r_busError;
`else
   assign w_timeout     = 1'b0;
   assign bus.bus_error = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_memCommand <= 2'd0;
         r_memAddress <= 20'd0;
         r_memDataOut <= 16'd0;
         r_euDataIn   <= 16'd0;
         r_pfDataIn   <= 16'd0;
         r_euDone     <= 1'b0;
         r_pfDone     <= 1'b0;
         r_busOwner   <= 2'd0;
         r_pfFlushed  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_euReq) begin
                  r_memCommand <= bus.eu_command;
                  r_memAddress <= bus.eu_address;
                  if (bus.eu_command == 2'd2) r_memDataOut <= bus.eu_data_out;
                  r_busOwner   <= 2'd1;
                  r_state      <= BUSY;
               end else if (w_pfReq) begin
                  r_memCommand <= 2'd1;
                  r_memAddress <= bus.pf_address;
                  r_busOwner   <= 2'd2;
                  r_state      <= BUSY;
               end
            end
            BUSY: begin
               if ((r_busOwner == 2'd2) && bus.pf_flush) r_pfFlushed <= 1'b1;
               if (bus.mem_ready || w_timeout) begin
                  r_memCommand <= 2'd0;
                  r_state      <= DONE;
                  if (r_busOwner == 2'd1) begin
                     r_euDone <= 1'b1;
                     if (r_memCommand == 2'd1) r_euDataIn <= w_rdData;
                  end else if ((r_busOwner == 2'd2) && w_pfKeep) begin
                     r_pfDone   <= 1'b1;
                     r_pfDataIn <= w_rdData;
                  end
               end
            end
            DONE: begin
               r_euDone    <= 1'b0;
               r_pfDone    <= 1'b0;
               r_busOwner  <= 2'd0;
               r_pfFlushed <= 1'b0;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.mem_command  = r_memCommand;
   assign bus.mem_address  = r_memAddress;
   assign bus.mem_data_out = r_memDataOut;
   assign bus.eu_data_in   = r_euDataIn;
   assign bus.pf_data_in   = r_pfDataIn;
   assign bus.eu_done      = r_euDone;
   assign bus.pf_done      = r_pfDone;
   assign bus.bus_owner    = r_busOwner;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter; covers arbitration, flush, reset abort
// and (when BUS_TIMEOUT_EN is defined) the BUSY timeout with TIMEOUT_CYCLES=4.
module tb_bus_arbiter;

   logic clk;
   logic reset;
   int   nCompared;
   int   nMismatched;

   bus_arbiter_if busIf ();

   bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (busIf.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] cmd, input logic [19:0] addr,
                                input logic [15:0] wdata, input logic pfReq,
                                input logic [19:0] pfAddr, input logic pfFlush,
                                input logic ready, input logic [15:0] rdata);
      busIf.eu_command  = cmd;
      busIf.eu_address  = addr;
      busIf.eu_data_out = wdata;
      busIf.pf_request  = pfReq;
      busIf.pf_address  = pfAddr;
      busIf.pf_flush    = pfFlush;
      busIf.mem_ready   = ready;
      busIf.mem_data_in = rdata;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nCompared++;
      assert (observed === expected)
      else begin
         nMismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      reset       = 1'b0;
      applyStimulus(2'd0, 20'h0, 16'h0, 1'b0, 20'h0, 1'b0, 1'b0, 16'h0);

      // Reset state
      stepClk();
      stepClk();
      checkOutput("rst_mem_command", 32'(busIf.mem_command), 32'd0);
      checkOutput("rst_bus_owner", 32'(busIf.bus_owner), 32'd0);
      checkOutput("rst_eu_data_in", 32'(busIf.eu_data_in), 32'h0);
      checkOutput("rst_pf_data_in", 32'(busIf.pf_data_in), 32'h0);
      checkOutput("rst_dones", 32'({busIf.eu_done, busIf.pf_done, busIf.bus_error}), 32'd0);
      reset = 1'b1;
      stepClk();

      // EU read 0x12345 with one-cycle memory latency
      $display("[TB] EU read, minimum latency");
      applyStimulus(2'd1, 20'h12345, 16'h0, 1'b0, 20'h0, 1'b0, 1'b0, 16'h0);
      stepClk();
      checkOutput("rd_mem_command", 32'(busIf.mem_command), 32'd1);
      checkOutput("rd_mem_address", 32'(busIf.mem_address), 32'h12345);
      checkOutput("rd_owner_busy", 32'(busIf.bus_owner), 32'd1);
      checkOutput("rd_done_early", 32'(busIf.eu_done), 32'd0);
      applyStimulus(2'd1, 20'h12345, 16'h0, 1'b0, 20'h0, 1'b0, 1'b1, 16'hBEEF);
      stepClk();
      checkOutput("rd_eu_done", 32'(busIf.eu_done), 32'd1);
      checkOutput("rd_eu_data_in", 32'(busIf.eu_data_in), 32'hBEEF);
      checkOutput("rd_cmd_cleared", 32'(busIf.mem_command), 32'd0);
      checkOutput("rd_owner_done", 32'(busIf.bus_owner), 32'd1);
      applyStimulus(2'd0, 20'h0, 16'h0, 1'b0, 20'h0, 1'b0, 1'b0, 16'h0);
      stepClk();
      checkOutput("rd_done_pulse", 32'(busIf.eu_done), 32'd0);
      checkOutput("rd_owner_idle", 32'(busIf.bus_owner), 32'd0);

      // EU write 0x00100 / A5A5, memory ready after three BUSY cycles
      $display("[TB] EU write, three-cycle memory");
      applyStimulus(2'd2, 20'h00100, 16'hA5A5, 1'b0, 20'h0, 1'b0, 1'b0, 16'h0);
      stepClk();
      checkOutput("wr_cmd_c1", 32'(busIf.mem_command), 32'd2);
      checkOutput("wr_data_out", 32'(busIf.mem_data_out), 32'hA5A5);
      checkOutput("wr_addr", 32'(busIf.mem_address), 32'h00100);
      applyStimulus(2'd2, 20'h00F00, 16'h0000, 1'b0, 20'h0, 1'b0, 1'b0, 16'h0);
      stepClk();
      checkOutput("wr_cmd_c2", 32'(busIf.mem_command), 32'd2);
      checkOutput("wr_addr_stable", 32'(busIf.mem_address), 32'h00100);
      checkOutput("wr_data_stable", 32'(busIf.mem_data_out), 32'hA5A5);
      stepClk();
      checkOutput("wr_cmd_c3", 32'(busIf.mem_command), 32'd2);
      applyStimulus(2'd2, 20'h00100, 16'hA5A5, 1'b0, 20'h0, 1'b0, 1'b1, 16'h1234);
      stepClk();
      checkOutput("wr_eu_done", 32'(busIf.eu_done), 32'd1);
      checkOutput("wr_eu_data_kept", 32'(busIf.eu_data_in), 32'hBEEF);
      checkOutput("wr_cmd_cleared", 32'(busIf.mem_command), 32'd0);
      applyStimulus(2'd0, 20'h0, 16'h0, 1'b0, 20'h0, 1'b0, 1'b0, 16'h0);
      stepClk();
      checkOutput("wr_done_once", 32'(busIf.eu_done), 32'd0);

      // Stray mem_ready while IDLE
      applyStimulus(2'd0, 20'h0, 16'h0, 1'b0, 20'h0, 1'b0, 1'b1, 16'h5555);
      stepClk();
      checkOutput("stray_owner", 32'(busIf.bus_owner), 32'd0);
      checkOutput("stray_done", 32'({busIf.eu_done, busIf.pf_done}), 32'd0);
      checkOutput("stray_eu_data", 32'(busIf.eu_data_in), 32'hBEEF);

      // Simultaneous EU read and prefetch: EU first, prefetch after DONE
      $display("[TB] EU and prefetch contention");
      applyStimulus(2'd1, 20'h0AAAA, 16'h0, 1'b1, 20'h0BBBB, 1'b0, 1'b0, 16'h0);
      stepClk();
      checkOutput("arb_owner_eu", 32'(busIf.bus_owner), 32'd1);
      checkOutput("arb_addr_eu", 32'(busIf.mem_address), 32'h0AAAA);
      applyStimulus(2'd1, 20'h0AAAA, 16'h0, 1'b1, 20'h0BBBB, 1'b0, 1'b1, 16'h1111);
      stepClk();
      checkOutput("arb_eu_done", 32'({busIf.eu_done, busIf.pf_done}), 32'b10);
      checkOutput("arb_eu_data", 32'(busIf.eu_data_in), 32'h1111);
      applyStimulus(2'd0, 20'h0, 16'h0, 1'b1, 20'h0BBBB, 1'b0, 1'b0, 16'h0);
      stepClk();
      checkOutput("arb_no_grant_done", 32'(busIf.bus_owner), 32'd0);
      checkOutput("arb_cmd_idle", 32'(busIf.mem_command), 32'd0);
      stepClk();
      checkOutput("arb_owner_pf", 32'(busIf.bus_owner), 32'd2);
      checkOutput("arb_addr_pf", 32'(busIf.mem_address), 32'h0BBBB);
      checkOutput("arb_cmd_pf", 32'(busIf.mem_command), 32'd1);
      applyStimulus(2'd0, 20'h0, 16'h0, 1'b1, 20'h0BBBB, 1'b0, 1'b1, 16'h2222);
      stepClk();
      checkOutput("arb_pf_done", 32'({busIf.eu_done, busIf.pf_done}), 32'b01);
      checkOutput("arb_pf_data", 32'(busIf.pf_data_in), 32'h2222);
      checkOutput("arb_eu_data_kept", 32'(busIf.eu_data_in), 32'h1111);
      applyStimulus(2'd0, 20'h0, 16'h0, 1'b0, 20'h0, 1'b0, 1'b0, 16'h0);
      stepClk();

      // pf_flush in IDLE blocks the prefetch grant
      applyStimulus(2'd0, 20'h0, 16'h0, 1'b1, 20'h0CCCC, 1'b1, 1'b0, 16'h0);
      stepClk();
      checkOutput("flush_idle_owner", 32'(busIf.bus_owner), 32'd0);
      checkOutput("flush_idle_cmd", 32'(busIf.mem_command), 32'd0);

      // Prefetch 0xFFFF0 flushed during BUSY
      $display("[TB] prefetch flushed mid-transaction");
      applyStimulus(2'd0, 20'h0, 16'h0, 1'b1, 20'hFFFF0, 1'b0, 1'b0, 16'h0);
      stepClk();
      checkOutput("pfl_owner", 32'(busIf.bus_owner), 32'd2);
      checkOutput("pfl_addr", 32'(busIf.mem_address), 32'hFFFF0);
      applyStimulus(2'd0, 20'h0, 16'h0, 1'b1, 20'hFFFF0, 1'b1, 1'b0, 16'h0);
      stepClk();
      checkOutput("pfl_cmd_held", 32'(busIf.mem_command), 32'd1);
      applyStimulus(2'd0, 20'h0, 16'h0, 1'b1, 20'hFFFF0, 1'b0, 1'b1, 16'h3333);
      stepClk();
      checkOutput("pfl_cmd_done", 32'(busIf.mem_command), 32'd0);
      checkOutput("pfl_no_done", 32'(busIf.pf_done), 32'd0);
      checkOutput("pfl_data_kept", 32'(busIf.pf_data_in), 32'h2222);
      applyStimulus(2'd0, 20'h0, 16'h0, 1'b0, 20'h0, 1'b0, 1'b0, 16'h0);
      stepClk();
      checkOutput("pfl_owner_idle", 32'(busIf.bus_owner), 32'd0);
      checkOutput("pfl_no_done_late", 32'(busIf.pf_done), 32'd0);

      // Asynchronous reset in the middle of BUSY
      $display("[TB] reset during BUSY");
      applyStimulus(2'd1, 20'h00555, 16'h0, 1'b0, 20'h0, 1'b0, 1'b0, 16'h0);
      stepClk();
      checkOutput("arst_busy_cmd", 32'(busIf.mem_command), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("arst_cmd_async", 32'(busIf.mem_command), 32'd0);
      checkOutput("arst_owner_async", 32'(busIf.bus_owner), 32'd0);
      checkOutput("arst_eu_data", 32'(busIf.eu_data_in), 32'h0);
      applyStimulus(2'd0, 20'h0, 16'h0, 1'b0, 20'h0, 1'b0, 1'b0, 16'h0);
      stepClk();
      reset = 1'b1;
      applyStimulus(2'd0, 20'h0, 16'h0, 1'b0, 20'h0, 1'b0, 1'b1, 16'h9999);
      for (int i = 0; i < 3; i++) begin
         stepClk();
         checkOutput("arst_no_done", 32'({busIf.eu_done, busIf.pf_done}), 32'd0);
      end
      applyStimulus(2'd0, 20'h0, 16'h0, 1'b0, 20'h0, 1'b0, 1'b0, 16'h0);
      stepClk();

`ifdef BUS_TIMEOUT_EN
      // EU read with no memory response: timeout after four BUSY cycles
      $display("[TB] BUSY timeout");
      applyStimulus(2'd1, 20'h00777, 16'h0, 1'b0, 20'h0, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 4; i++) begin
         stepClk();
         checkOutput("to_busy_cmd", 32'(busIf.mem_command), 32'd1);
         checkOutput("to_busy_err", 32'(busIf.bus_error), 32'd0);
      end
      stepClk();
      checkOutput("to_done_err", 32'({busIf.eu_done, busIf.bus_error}), 32'b11);
      checkOutput("to_eu_data", 32'(busIf.eu_data_in), 32'hFFFF);
      checkOutput("to_cmd_cleared", 32'(busIf.mem_command), 32'd0);
      applyStimulus(2'd0, 20'h0, 16'h0, 1'b0, 20'h0, 1'b0, 1'b0, 16'h0);
      stepClk();
      checkOutput("to_err_pulse", 32'(busIf.bus_error), 32'd0);

      // mem_ready on the timeout cycle completes normally
      applyStimulus(2'd1, 20'h00778, 16'h0, 1'b0, 20'h0, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 4; i++) stepClk();
      applyStimulus(2'd1, 20'h00778, 16'h0, 1'b0, 20'h0, 1'b0, 1'b1, 16'h7777);
      stepClk();
      checkOutput("to_race_done", 32'({busIf.eu_done, busIf.bus_error}), 32'b10);
      checkOutput("to_race_data", 32'(busIf.eu_data_in), 32'h7777);
      applyStimulus(2'd0, 20'h0, 16'h0, 1'b0, 20'h0, 1'b0, 1'b0, 16'h0);
      stepClk();
`else
      // Without the watchdog, BUSY waits for mem_ready indefinitely
      $display("[TB] BUSY without timeout");
      applyStimulus(2'd1, 20'h00777, 16'h0, 1'b0, 20'h0, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 8; i++) stepClk();
      checkOutput("nto_cmd_held", 32'(busIf.mem_command), 32'd1);
      checkOutput("nto_no_done", 32'({busIf.eu_done, busIf.bus_error}), 32'd0);
      applyStimulus(2'd1, 20'h00777, 16'h0, 1'b0, 20'h0, 1'b0, 1'b1, 16'h6666);
      stepClk();
      checkOutput("nto_done", 32'({busIf.eu_done, busIf.bus_error}), 32'b10);
      checkOutput("nto_data", 32'(busIf.eu_data_in), 32'h6666);
      applyStimulus(2'd0, 20'h0, 16'h0, 1'b0, 20'h0, 1'b0, 1'b0, 16'h0);
      stepClk();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 64, maximum BUSY cycles before abort; used only when BUS_TIMEOUT_EN is defined.
REQ-002 SHALL have ports (name direction width meaning):
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- eu_command  input  2  execution-unit command: 0 idle, 1 read, 2 write, 3 treated as idle.
- eu_address  input  20  EU physical address.
- eu_data_out  input  16  EU write data.
- eu_data_in  output  16  EU read data, registered.
- eu_done  output  1  one-cycle EU completion pulse.
- pf_request  input  1  prefetch read request.
- pf_address  input  20  prefetch physical address.
- pf_flush  input  1  discard in-flight prefetch (jump/branch).
- pf_data_in  output  16  prefetch read data, registered.
- pf_done  output  1  one-cycle prefetch completion pulse.
- mem_command  output  2  memory command: 0 idle, 1 read, 2 write.
- mem_address  output  20  memory address.
- mem_data_out  output  16  memory write data.
- mem_data_in  input  16  memory read data, valid with mem_ready.
- mem_ready  input  1  memory transaction complete.
- bus_owner  output  2  0 none, 1 EU, 2 prefetch.
- bus_error  output  1  one-cycle timeout pulse.

Function
REQ-003 SHALL implement states IDLE, BUSY, DONE; all outputs registered.
REQ-004 In IDLE, SHALL sample requests each edge; EU command 1/2 wins; else pf_request grants a prefetch read; else stay IDLE.
REQ-005 On grant SHALL enter BUSY next cycle with mem_command, mem_address (and mem_data_out for writes) latched from the winner, bus_owner set.
REQ-006 SHALL hold mem_command/address/data stable throughout BUSY regardless of requester inputs.
REQ-007 On mem_ready in BUSY SHALL capture mem_data_in into owner's data register (reads only), drive mem_command=0, enter DONE.
REQ-008 In DONE (exactly one cycle) SHALL assert owner's done, then return to IDLE with bus_owner=0; no grant evaluated in DONE.
REQ-009 Minimum latency: request seen in IDLE at cycle 0 -> mem_command cycle 1 -> mem_ready cycle 1 -> done cycle 2 -> IDLE cycle 3.
REQ-010 Requesters SHALL hold command/request until done; arbiter relies on deassertion by the edge ending DONE.
REQ-011 eu_data_in/pf_data_in SHALL retain value until the next read completion for that owner; writes leave eu_data_in unchanged.
REQ-012 pf_flush during BUSY/DONE with prefetch owner: memory transaction completes normally, pf_done suppressed, pf_data_in unchanged.
REQ-013 pf_flush in IDLE SHALL block a prefetch grant that cycle; EU grant unaffected.
REQ-014 Simultaneous EU and prefetch requests: EU granted; prefetch waits, no starvation protection.
REQ-015 mem_ready outside BUSY SHALL be ignored.

Reset
REQ-016 reset low SHALL immediately force IDLE, mem_command=0, mem_address=0, mem_data_out=0, bus_owner=0, eu_done=0, pf_done=0, bus_error=0, eu_data_in=0, pf_data_in=0, timeout counter=0.
REQ-017 Reset during BUSY SHALL abandon the transaction; no done pulse after release.

Configuration
REQ-018 With BUS_TIMEOUT_EN defined, SHALL count BUSY cycles; at TIMEOUT_CYCLES without mem_ready, drive mem_command=0, load 16'hFFFF into owner's data register (reads), enter DONE, pulse bus_error with done.
REQ-019 mem_ready on the timeout cycle SHALL take precedence (normal completion, no bus_error).
REQ-020 Without BUS_TIMEOUT_EN: no counter, bus_error constant 0, BUSY waits indefinitely.

Verification
REQ-021 EU read 0x12345, mem_ready 1 cycle after mem_command, mem_data_in=16'hBEEF -> eu_done cycle 2, eu_data_in=16'hBEEF, bus_owner 1 then 0.
REQ-022 EU write 0x00100 data 16'hA5A5, mem_ready after 3 cycles -> mem_command=2 held 3 cycles, mem_data_out=16'hA5A5, eu_done once, eu_data_in unchanged.
REQ-023 EU read and pf_request same cycle -> EU served first; prefetch granted in the IDLE after EU DONE; pf_done with pf_data_in.
REQ-024 Prefetch read 0xFFFF0 with pf_flush pulsed during BUSY -> mem transaction completes, no pf_done, pf_data_in unchanged.
REQ-025 reset low mid-BUSY -> mem_command=0 asynchronously; after release no eu_done/pf_done.
REQ-026 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, EU read, mem_ready never -> after 4 BUSY cycles eu_done and bus_error together, eu_data_in=16'hFFFF.
